// File: rtl/oam_dma_if.sv
// Bus bundle for the OAM DMA engine: CPU register port, source read port and OAM write port.
// The slave side is the DMA engine; the master side is the surrounding system.
interface oam_dma_if;
    logic        reg_we;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        dma_active;
    logic        src_rd;
    logic [15:0] src_addr;
    logic [7:0]  src_data;
    logic        src_valid;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;

    modport slave (
        input  reg_we, reg_addr, reg_wdata, src_data, src_valid,
        output reg_rdata, dma_active, src_rd, src_addr, oam_we, oam_addr, oam_wdata
    );

    modport master (
        output reg_we, reg_addr, reg_wdata, src_data, src_valid,
        input  reg_rdata, dma_active, src_rd, src_addr, oam_we, oam_addr, oam_wdata
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to the page register copies LENGTH bytes from that page
// into OAM, one source read and one OAM write per byte.
module oam_dma #(
    parameter logic [15:0] REG_ADDR    = 16'hFF46,
    parameter int          LENGTH      = 160,
    parameter int          START_DELAY = 1
) (
    input logic      clk,
    input logic      reset,
    oam_dma_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, READ, WAIT, WRITE} state_t;

    localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);
    localparam logic [3:0] LAST_DELAY = 4'(START_DELAY - 1);

    state_t     state, state_next;
    logic [7:0] page, index, src_hi;
    logic [7:0] oam_addr_reg, oam_wdata_reg, rdata_reg;
    logic [3:0] delay_cnt;
    logic       accept;

    assign accept = bus.reg_we && (bus.reg_addr == REG_ADDR);

    // Pages E0-FF are the echo of work RAM at C0-DF
    assign src_hi = (page >= 8'hE0) ? page - 8'h20 : page;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        bus.dma_active = (state != IDLE);
        bus.src_rd     = 1'b0;
        bus.src_addr   = 16'h0000;
        bus.oam_we     = 1'b0;
        case (state)
            START: begin
                if (delay_cnt == LAST_DELAY) state_next = READ;
            end
            READ: begin
                bus.src_rd   = 1'b1;
                bus.src_addr = {src_hi, index};
                state_next   = WAIT;
            end
            WAIT: begin
                if (bus.src_valid) state_next = WRITE;
            end
            WRITE: begin
                bus.oam_we = 1'b1;
                state_next = (index == LAST_INDEX) ? IDLE : READ;
            end
            default: ;
        endcase
        // A register write restarts from any state and wins over a returning read
        if (accept) state_next = START;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            page          <= 8'h00;
            index         <= 8'h00;
            delay_cnt     <= 4'h0;
            oam_addr_reg  <= 8'h00;
            oam_wdata_reg <= 8'h00;
            rdata_reg     <= 8'h00;
        end else if (accept) begin
            page      <= bus.reg_wdata;
            rdata_reg <= bus.reg_wdata;
            index     <= 8'h00;
            delay_cnt <= 4'h0;
        end else begin
            case (state)
                START: delay_cnt <= delay_cnt + 4'd1;
                WAIT: begin
                    if (bus.src_valid) begin
                        oam_wdata_reg <= bus.src_data;
                        oam_addr_reg  <= index;
                    end
                end
                WRITE: begin
                    if (index != LAST_INDEX) index <= index + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.oam_addr  = oam_addr_reg;
    assign bus.oam_wdata = oam_wdata_reg;
    assign bus.reg_rdata = rdata_reg;
endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: memory returns addr[7:0]^8'h5A after a programmable latency,
// and a negedge monitor logs every source read and OAM write.
module tb_oam_dma;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    oam_dma_if bus();

    oam_dma #(.REG_ADDR(16'hFF46), .LENGTH(160), .START_DELAY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    int         mem_latency = 1;
    int         mem_cnt     = 0;
    logic [7:0] mem_lo;

    logic [7:0]  we_addr [0:1023];
    logic [7:0]  we_data [0:1023];
    logic [15:0] rd_addr [0:1023];
    int we_count = 0;
    int rd_count = 0;
    int active_cycles = 0;

    // Source memory: one outstanding read, data valid mem_latency cycles after src_rd
    always @(posedge clk) begin
        bus.src_valid <= 1'b0;
        if (bus.src_rd === 1'b1) begin
            if (mem_latency <= 1) begin
                bus.src_valid <= 1'b1;
                bus.src_data  <= bus.src_addr[7:0] ^ 8'h5A;
            end else begin
                mem_cnt <= mem_latency - 1;
                mem_lo  <= bus.src_addr[7:0];
            end
        end else if (mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
            if (mem_cnt == 1) begin
                bus.src_valid <= 1'b1;
                bus.src_data  <= mem_lo ^ 8'h5A;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.oam_we === 1'b1 && we_count < 1024) begin
            we_addr[we_count] = bus.oam_addr;
            we_data[we_count] = bus.oam_wdata;
            we_count++;
        end
        if (bus.src_rd === 1'b1 && rd_count < 1024) begin
            rd_addr[rd_count] = bus.src_addr;
            rd_count++;
        end
        if (bus.dma_active === 1'b1) active_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic we);
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        bus.reg_we    = we;
        tick();
        bus.reg_we    = 1'b0;
    endtask

    task automatic clear_logs();
        we_count      = 0;
        rd_count      = 0;
        active_cycles = 0;
    endtask

    task automatic wait_idle(input int max_cycles, output logic timed_out);
        int n = 0;
        while (bus.dma_active === 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        timed_out = (bus.dma_active !== 1'b0);
    endtask

    // Number of OAM writes from log position start that break the idx / idx^5A pattern
    function automatic int seq_errors(input int start, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (we_addr[start + i] !== 8'(i) || we_data[start + i] !== (8'(i) ^ 8'h5A)) bad++;
        end
        return bad;
    endfunction

    function automatic int rd_errors(input int start, input int n, input logic [15:0] base);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (rd_addr[start + i] !== base + 16'(i)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        string       nm [7];
        logic [15:0] act [7];
        reset         = 1'b1;
        bus.reg_addr  = 16'hFF46;
        bus.reg_wdata = 8'hAA;
        bus.reg_we    = 1'b1;
        tick();
        tick();
        nm  = '{"dma_active", "src_rd", "src_addr", "oam_we", "oam_addr", "oam_wdata", "reg_rdata"};
        act = '{16'(bus.dma_active), 16'(bus.src_rd), bus.src_addr, 16'(bus.oam_we),
                16'(bus.oam_addr), 16'(bus.oam_wdata), 16'(bus.reg_rdata)};
        for (int i = 0; i < 7; i++) begin
            n_compared++;
            if (act[i] !== 16'h0000) begin
                n_mismatched++;
                $display("[TB] FAIL reset_%s: got %h want 0000", nm[i], act[i]);
            end
        end
        bus.reg_we = 1'b0;
        reset      = 1'b0;
        tick();
        n_compared++;
        if (bus.dma_active !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_overrides_write: dma_active got %b want 0", bus.dma_active);
        end
    endtask

    task automatic test_basic();
        logic to;
        mem_latency = 1;
        clear_logs();
        cpu_write(16'hFF46, 8'hC1, 1'b1);
        n_compared++;
        if (bus.dma_active !== 1'b1 || bus.oam_we !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_start: active/oam_we got %b/%b want 1/0", bus.dma_active, bus.oam_we);
        end
        wait_idle(2000, to);
        n_compared++;
        if (to !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_timeout: dma_active still %b want 0", bus.dma_active);
        end
        n_compared++;
        if (we_count !== 160) begin
            n_mismatched++;
            $display("[TB] FAIL basic_we_count: got %0d want 160", we_count);
        end
        n_compared++;
        if (seq_errors(0, 160) !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_oam_seq: bad entries got %0d want 0", seq_errors(0, 160));
        end
        n_compared++;
        if (rd_count !== 160 || rd_errors(0, 160, 16'hC100) !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_src_addr: reads %0d bad %0d want 160 reads 0 bad",
                     rd_count, rd_errors(0, 160, 16'hC100));
        end
        n_compared++;
        if (active_cycles !== 481) begin
            n_mismatched++;
            $display("[TB] FAIL basic_active_cycles: got %0d want 481", active_cycles);
        end
        n_compared++;
        if (bus.reg_rdata !== 8'hC1) begin
            n_mismatched++;
            $display("[TB] FAIL basic_rdata: got %h want c1", bus.reg_rdata);
        end
        tick();
        n_compared++;
        if (bus.oam_addr !== 8'h9F || bus.oam_wdata !== 8'hC5) begin
            n_mismatched++;
            $display("[TB] FAIL basic_hold: oam_addr/wdata got %h/%h want 9f/c5", bus.oam_addr, bus.oam_wdata);
        end
        n_compared++;
        if (bus.src_rd !== 1'b0 || bus.src_addr !== 16'h0000 || bus.oam_we !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_idle_outputs: src_rd/src_addr/oam_we got %b/%h/%b want 0/0000/0",
                     bus.src_rd, bus.src_addr, bus.oam_we);
        end
    endtask

    task automatic test_ignored();
        clear_logs();
        cpu_write(16'hFF47, 8'h33, 1'b1);
        tick();
        n_compared++;
        if (bus.dma_active !== 1'b0 || bus.reg_rdata !== 8'hC1) begin
            n_mismatched++;
            $display("[TB] FAIL ignored_other_addr: active/rdata got %b/%h want 0/c1", bus.dma_active, bus.reg_rdata);
        end
        cpu_write(16'hFF46, 8'h44, 1'b0);
        tick();
        n_compared++;
        if (bus.dma_active !== 1'b0 || bus.reg_rdata !== 8'hC1 || we_count !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL ignored_no_we: active/rdata/writes got %b/%h/%0d want 0/c1/0",
                     bus.dma_active, bus.reg_rdata, we_count);
        end
    endtask

    task automatic test_echo();
        logic [7:0]  pages [4] = '{8'hE3, 8'hE0, 8'hDF, 8'hFF};
        logic [15:0] bases [4] = '{16'hC300, 16'hC000, 16'hDF00, 16'hDF00};
        logic to;
        mem_latency = 1;
        for (int p = 0; p < 4; p++) begin
            clear_logs();
            cpu_write(16'hFF46, pages[p], 1'b1);
            wait_idle(2000, to);
            n_compared++;
            if (to !== 1'b0 || rd_count !== 160 || rd_addr[0] !== bases[p]) begin
                n_mismatched++;
                $display("[TB] FAIL echo_first_addr page %h: timeout %b reads %0d first %h want 0/160/%h",
                         pages[p], to, rd_count, rd_addr[0], bases[p]);
            end
            n_compared++;
            if (rd_errors(0, 160, bases[p]) !== 0 || seq_errors(0, 160) !== 0 || we_count !== 160) begin
                n_mismatched++;
                $display("[TB] FAIL echo_transfer page %h: bad reads %0d bad writes %0d writes %0d want 0/0/160",
                         pages[p], rd_errors(0, 160, bases[p]), seq_errors(0, 160), we_count);
            end
        end
    endtask

    task automatic test_wait_states();
        logic to;
        mem_latency = 2;
        clear_logs();
        cpu_write(16'hFF46, 8'hC5, 1'b1);
        wait_idle(4000, to);
        n_compared++;
        if (to !== 1'b0 || we_count !== 160) begin
            n_mismatched++;
            $display("[TB] FAIL wait_we_count: timeout %b writes %0d want 0/160", to, we_count);
        end
        n_compared++;
        if (seq_errors(0, 160) !== 0 || rd_errors(0, 160, 16'hC500) !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL wait_data: bad writes %0d bad reads %0d want 0/0",
                     seq_errors(0, 160), rd_errors(0, 160, 16'hC500));
        end
        n_compared++;
        if (active_cycles !== 641) begin
            n_mismatched++;
            $display("[TB] FAIL wait_active_cycles: got %0d want 641", active_cycles);
        end
        mem_latency = 1;
    endtask

    task automatic test_restart();
        logic to;
        int n = 0;
        int we_mark, rd_mark, act_mark;
        mem_latency = 1;
        clear_logs();
        cpu_write(16'hFF46, 8'hC0, 1'b1);
        while (!(we_count >= 51 && bus.src_valid === 1'b1) && n < 2000) begin
            tick();
            n++;
        end
        we_mark = we_count;
        rd_mark = rd_count;
        n_compared++;
        if (we_mark !== 51 || we_addr[50] !== 8'd50 || rd_mark !== 52) begin
            n_mismatched++;
            $display("[TB] FAIL restart_setup: writes %0d reads %0d want 51/52", we_mark, rd_mark);
        end
        cpu_write(16'hFF46, 8'hD0, 1'b1);
        act_mark = active_cycles;
        n_compared++;
        if (bus.oam_we !== 1'b0 || bus.dma_active !== 1'b1 || bus.reg_rdata !== 8'hD0) begin
            n_mismatched++;
            $display("[TB] FAIL restart_discard: oam_we/active/rdata got %b/%b/%h want 0/1/d0",
                     bus.oam_we, bus.dma_active, bus.reg_rdata);
        end
        wait_idle(2000, to);
        n_compared++;
        if (to !== 1'b0 || we_count - we_mark !== 160 || seq_errors(we_mark, 160) !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL restart_writes: timeout %b new writes %0d bad %0d want 0/160/0",
                     to, we_count - we_mark, seq_errors(we_mark, 160));
        end
        n_compared++;
        if (rd_count - rd_mark !== 160 || rd_errors(rd_mark, 160, 16'hD000) !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL restart_reads: new reads %0d bad %0d want 160/0",
                     rd_count - rd_mark, rd_errors(rd_mark, 160, 16'hD000));
        end
        n_compared++;
        if (active_cycles - act_mark !== 481) begin
            n_mismatched++;
            $display("[TB] FAIL restart_active_cycles: got %0d want 481", active_cycles - act_mark);
        end
    endtask

    task automatic test_reset_midway();
        string       nm [7];
        logic [15:0] act [7];
        logic to;
        int n = 0;
        int we_mark;
        mem_latency = 1;
        clear_logs();
        cpu_write(16'hFF46, 8'hC2, 1'b1);
        while (we_count < 81 && n < 2000) begin
            tick();
            n++;
        end
        n_compared++;
        if (we_count !== 81) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_setup: writes got %0d want 81", we_count);
        end
        reset = 1'b1;
        tick();
        nm  = '{"dma_active", "src_rd", "src_addr", "oam_we", "oam_addr", "oam_wdata", "reg_rdata"};
        act = '{16'(bus.dma_active), 16'(bus.src_rd), bus.src_addr, 16'(bus.oam_we),
                16'(bus.oam_addr), 16'(bus.oam_wdata), 16'(bus.reg_rdata)};
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_compared++;
            if (act[i] !== 16'h0000) begin
                n_mismatched++;
                $display("[TB] FAIL midreset_%s: got %h want 0000", nm[i], act[i]);
            end
        end
        we_mark = we_count;
        for (int i = 0; i < 20; i++) tick();
        n_compared++;
        if (we_count !== we_mark || bus.dma_active !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_quiet: extra writes %0d active %b want 0/0",
                     we_count - we_mark, bus.dma_active);
        end
        clear_logs();
        cpu_write(16'hFF46, 8'hC4, 1'b1);
        wait_idle(2000, to);
        n_compared++;
        if (to !== 1'b0 || we_count !== 160 || seq_errors(0, 160) !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_clean_writes: timeout %b writes %0d bad %0d want 0/160/0",
                     to, we_count, seq_errors(0, 160));
        end
        n_compared++;
        if (rd_errors(0, 160, 16'hC400) !== 0 || active_cycles !== 481) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_clean_reads: bad reads %0d active %0d want 0/481",
                     rd_errors(0, 160, 16'hC400), active_cycles);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.reg_we    = 1'b0;
        bus.reg_addr  = 16'h0000;
        bus.reg_wdata = 8'h00;
        bus.src_valid = 1'b0;
        bus.src_data  = 8'h00;
        test_reset();
        test_basic();
        test_ignored();
        test_echo();
        test_wait_states();
        test_restart();
        test_reset_midway();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
